// File: rtl/acq_upload_arbiter_pkg.sv
// Shared types and constants for the acquisition upload arbiter.
// The frame header magic sits in the top 16 bits of every header word.
package acq_upload_arbiter_pkg;

    typedef enum logic [1:0] {
        UPL_IDLE,
        UPL_HDR,
        UPL_DATA
    } acqUploadState_t;

    localparam logic [15:0] ACQ_UPLOAD_MAGIC = 16'hA5C3;

endpackage

// File: rtl/acq_upload_arbiter_next_ch.sv
// Finds the lowest set mask bit above cur (or at cur when include_cur is set).
// Used both to pick a frame's first channel and to step to the next channel.
module acq_next_ch #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] cur,
    input  logic          include_cur,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan downward so the last hit written is the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (include_cur && (i == int'(cur))))) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/acq_upload_arbiter.sv
// Shares the PC upload stream between channel sample streams: one header word per frame,
// then one sample per enabled channel in ascending order, with a per-sample stall timeout.
module acq_upload_arbiter
    import acq_upload_arbiter_pkg::*;
#(
    parameter int unsigned CH_NUM  = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [31:0] FILL    = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [CH_NUM-1:0]          ch_mask,
    input  logic [CH_NUM-1:0][DW-1:0]  ch_data,
    input  logic [CH_NUM-1:0]          ch_valid,
    output logic [CH_NUM-1:0]          ch_ready,
    output logic [DW-1:0]              m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic [7:0]                 frame_cnt,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       err_clr
);

    localparam int unsigned IW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

    acqUploadState_t   state_q, state_d;
    logic [CH_NUM-1:0] mask_q, mask_d;
    logic [IW-1:0]     sel_q, sel_d;
    logic [31:0]       wait_q, wait_d;
    logic [DW-1:0]     m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;

    logic              free;
    logic              first_found, next_found;
    logic [IW-1:0]     first_idx, next_idx;

    acq_next_ch #(.N(CH_NUM), .IW(IW)) u_first_ch (
        .mask        (ch_mask),
        .cur         ('0),
        .include_cur (1'b1),
        .found       (first_found),
        .idx         (first_idx)
    );

    acq_next_ch #(.N(CH_NUM), .IW(IW)) u_next_ch (
        .mask        (mask_q),
        .cur         (sel_q),
        .include_cur (1'b0),
        .found       (next_found),
        .idx         (next_idx)
    );

    assign free = !m_valid_q || m_ready;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end
        // A consumed word empties the register unless something reloads it below.
        if (free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        unique case (state_q)
            UPL_IDLE: begin
                if (en && first_found && free) begin
                    state_d = UPL_HDR;
                    mask_d  = ch_mask;
                    sel_d   = first_idx;
                    wait_d  = '0;
                end
            end
            UPL_HDR: begin
                if (free) begin
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b0;
                    m_data_d    = DW'({ACQ_UPLOAD_MAGIC, frame_cnt_q, 8'(mask_q)});
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = UPL_DATA;
                end
            end
            UPL_DATA: begin
                if (free) begin
                    if (ch_valid[sel_q] || ((TIMEOUT != 0) && (wait_q == WAIT_LAST))) begin
                        m_valid_d = 1'b1;
                        m_last_d  = !next_found;
                        wait_d    = '0;
                        if (ch_valid[sel_q]) begin
                            m_data_d = ch_data[sel_q];
                        end else begin
                            m_data_d = DW'(FILL);
                            err_d    = 1'b1;
                        end
                        if (next_found) begin
                            sel_d = next_idx;
                        end else begin
                            state_d = UPL_IDLE;
                        end
                    end else begin
                        wait_d = wait_q + 32'd1;
                    end
                end
            end
            default: state_d = UPL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UPL_IDLE;
            mask_q      <= '0;
            sel_q       <= '0;
            wait_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    // A timed-out channel is never handshaken: ready tracks only the live output slot.
    always_comb begin
        ch_ready = '0;
        if ((state_q == UPL_DATA) && free) begin
            ch_ready[sel_q] = 1'b1;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != UPL_IDLE) || m_valid_q;

endmodule
